// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and timing constants for the key conditioner
package key_pkg;

  // Per-channel debounce/repeat state
  typedef enum logic [1:0] {
    S_UP     = 2'd0,
    S_DN_CHK = 2'd1,
    S_HELD   = 2'd2,
    S_UP_CHK = 2'd3
  } key_state_t;

  // Board timing at 16 MHz: 20 ms debounce, 0.5 s first repeat, 0.2 s repeat rate
  localparam int KEY_DEB_CYC      = 320000;
  localparam int KEY_REPEAT_DELAY = 8000000;
  localparam int KEY_REPEAT_RATE  = 3200000;

  // Shortened timing so simulations finish in a few thousand cycles
  localparam int KEY_SIM_DEB_CYC      = 4;
  localparam int KEY_SIM_REPEAT_DELAY = 10;
  localparam int KEY_SIM_REPEAT_RATE  = 5;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int key_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Larger of two cycle counts, used to size the shared repeat counter
  function automatic int key_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one button: synchroniser, debounce FSM and auto-repeat counter
module key_channel
  import key_pkg::*;
#(
  parameter int   DEB_CYC      = KEY_DEB_CYC,
  parameter int   REPEAT_DELAY = KEY_REPEAT_DELAY,
  parameter int   REPEAT_RATE  = KEY_REPEAT_RATE,
  parameter logic REPEAT_EN    = 1'b0
) (
  input  logic clk_16,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse,
  output logic level
);

  localparam int CNT_W = key_cnt_w(DEB_CYC);
  localparam int REP_W = key_cnt_w(key_max(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYC - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic sync_meta;
  logic sync;

  key_state_t       state;
  key_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_nx;
  logic             first;
  logic             first_nx;
  logic             pulse_nx;
  logic             level_nx;
  logic             rep_hit;

  // Two-flop synchroniser; both stages reset to "released" so a key held
  // through reset is seen as a fresh press afterwards
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
    end else begin
      sync_meta <= btn_n;
      sync      <= sync_meta;
    end
  end

  // First repeat waits the long delay, later ones use the faster rate
  assign rep_hit = (rep == (first ? DELAY_LAST : RATE_LAST));

  // Next-state logic: counters restart on every state entry, so they never
  // run past their compare values and need no saturation
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rep_nx   = rep;
    first_nx = first;
    pulse_nx = 1'b0;
    case (state)
      S_UP: begin
        if (!sync) begin
          state_nx = S_DN_CHK;
          cnt_nx   = '0;
        end
      end
      S_DN_CHK: begin
        if (sync) begin
          state_nx = S_UP;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_HELD;
          pulse_nx = 1'b1;
          rep_nx   = '0;
          first_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (sync) begin
          state_nx = S_UP_CHK;
          cnt_nx   = '0;
        end else if (REPEAT_EN) begin
          if (rep_hit) begin
            pulse_nx = 1'b1;
            rep_nx   = '0;
            first_nx = 1'b0;
          end else begin
            rep_nx = rep + 1'b1;
          end
        end
      end
      S_UP_CHK: begin
        // A short release glitch returns to S_HELD with the repeat
        // schedule paused rather than restarted
        if (!sync) begin
          state_nx = S_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_UP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_UP;
        cnt_nx   = '0;
      end
    endcase
  end

  // Debounced level follows the state being entered, registered with it
  assign level_nx = (state_nx == S_HELD) || (state_nx == S_UP_CHK);

  // State, counters and registered outputs
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_UP;
      cnt   <= '0;
      rep   <= '0;
      first <= 1'b1;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rep   <= rep_nx;
      first <= first_nx;
      pulse <= pulse_nx;
      level <= level_nx;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N independent debounced push-button channels with pulse and level outputs
module key_conditioner
  import key_pkg::*;
#(
  parameter int               N_BTN        = 2,
  parameter int               DEB_CYC      = KEY_DEB_CYC,
  parameter int               REPEAT_DELAY = KEY_REPEAT_DELAY,
  parameter int               REPEAT_RATE  = KEY_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_EN    = {N_BTN{1'b0}}
) (
  input  logic             clk_16,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] level
);

  // Channels share nothing but clock and reset
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    key_channel #(
      .DEB_CYC      (DEB_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_EN[i])
    ) u_ch (
      .clk_16 (clk_16),
      .rst_n  (rst_n),
      .btn_n  (btn_n[i]),
      .pulse  (pulse[i]),
      .level  (level[i])
    );
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Multi-channel push-button conditioner feeding the traffic countdown timer. It takes the raw active-low DE-board KEY inputs (countUp, countDn, spare) and synchronises them into clk_16. It debounces them and emits clean single-cycle `pulse` strobes plus a debounced `level`, with optional auto-repeat while a key is held. The countdown block consumes `pulse` directly, so it never needs its own per-button debounce FSM.

## Interface
- N_BTN, 2: number of independent button channels.
- DEB_CYC, 320000: stable-sample count for press/release acceptance (20 ms at 16 MHz); must be ≥2.
- REPEAT_DELAY, 8000000: cycles from the press pulse to the first repeat pulse (0.5 s).
- REPEAT_RATE, 3200000: cycles between subsequent repeat pulses (0.2 s).
- REPEAT_EN, {N_BTN{1'b0}}: per-channel auto-repeat enable mask.

Ports:
- clk_16  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_n  in  N_BTN  raw asynchronous buttons, 0 = pressed.
- pulse  out  N_BTN  registered one-cycle strobe per accepted press or repeat.
- level  out  N_BTN  registered debounced state, 1 = held.

## Operation
- Channels are fully independent. Simultaneous activity on several channels produces simultaneous, unrelated pulses.
- Each channel has a 2-FF synchroniser, both flops reset to 1 (released). `sync` is the second flop.
- Per-channel FSM with a debounce counter `cnt` (width clog2(DEB_CYC)), a repeat counter `rep` (width clog2(max(REPEAT_DELAY, REPEAT_RATE))), and a `first` flag.
  - S_UP: if sync==0, go to S_DN_CHK with cnt=0.
  - S_DN_CHK: if sync==1, return to S_UP (bounce, no pulse). If cnt==DEB_CYC-1, go to S_HELD with pulse<=1, rep=0, first=1. Otherwise cnt++.
  - S_HELD: if sync==1, go to S_UP_CHK with cnt=0 and rep frozen. Otherwise, when REPEAT_EN[i] is set, rep++. When rep==(first ? REPEAT_DELAY-1 : REPEAT_RATE-1), set pulse<=1, rep=0, first=0.
  - S_UP_CHK: if sync==0, return to S_HELD (release bounce) with rep and first kept. If cnt==DEB_CYC-1, go to S_UP. Otherwise cnt++.
- level is 1 in S_HELD and S_UP_CHK, and 0 elsewhere.
- pulse defaults to 0 every cycle, so it is never high for two consecutive cycles.
- Counters saturate-free: each counter is reset on every state entry and can never exceed its compare value.
- Reset, including mid-press or mid-repeat: all channels go to S_UP with counters 0. pulse=0, level=0, synchronisers=1. A key held through reset release is treated as a new press.

## Timing
- Edge 0 is the first posedge sampling btn_n[i]=0 after stable release.
- Sequence: sync low after edge 1, S_DN_CHK entered at edge 2, S_HELD entered at edge DEB_CYC+2. pulse is high for the single cycle following edge DEB_CYC+2.
- The first repeat pulse follows edge DEB_CYC+2+REPEAT_DELAY. Later repeat pulses occur every REPEAT_RATE cycles.
- Release: level drops in the cycle after edge (release edge 0)+DEB_CYC+2.
- Any bounce shorter than DEB_CYC consecutive cycles is invisible at the outputs.
- Reset values: pulse=0, level=0. No combinational path from input to output.

## Structure
- Shared package key_pkg:
  - 2-bit state encoding S_UP=0, S_DN_CHK=1, S_HELD=2, S_UP_CHK=3.
  - Default timing constants KEY_DEB_CYC, KEY_REPEAT_DELAY, KEY_REPEAT_RATE for 16 MHz.
  - Test-scale constants for simulation.
- Sub-module key_channel: one synchroniser, FSM, and counters, with a 1-bit REPEAT_EN parameter. key_conditioner is a generate loop instantiating N_BTN copies.

## Test plan
All directed tests use DEB_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=5, N_BTN=2.

- Clean press of btn_n[0] held 30 cycles with REPEAT_EN=0: exactly one pulse[0], high only after edge 6. level[0] rises with the pulse and falls 6 cycles after release. pulse[1] stays 0.
- Press with bounce (0,1,0,0,1 over 5 cycles, then stable 0): no pulse during the bounce. A single pulse arrives 6 edges after the last 1→0 transition.
- REPEAT_EN=2'b01, btn_n[0] held 40 cycles: pulses after edges 6, 16, 21, 26, 31, 36, 41.
- Release glitch while held (1 for 2 cycles): level[0] stays 1, no extra pulse, and the repeat schedule is not restarted.
- Both buttons pressed on the same edge: pulse[0] and pulse[1] are high in the same cycle, once each.
- rst_n asserted mid-hold, then released with the key still pressed: outputs are 0 during reset. A fresh pulse arrives 6 edges after reset release.
